// File: rtl/flag_register_stack.sv
// Purpose: status flag register with per-bit masked load, condition-code evaluation, and a LIFO shadow stack.
// Latency: loads, pushes and pops take effect on the next rising edge; Cond_True is combinational (0 cycles).
// Backpressure: none; an illegal push/pop is dropped and raises the sticky Stk_Err.
//
// Ports:
//   Clk, Rst_n             clock (rising edge), asynchronous active-low reset
//   Flags_in, Flag_Mask    ALU flag values and per-bit load enables (qualified by FR_Ld)
//   FR_Ld, Push, Pop       load / save-to-stack / restore-from-stack commands
//   Err_Clr                clears the sticky stack error
//   Cond                   4-bit branch condition evaluated against Flags_out
//   Flags_out, Cond_True   registered flags, condition result
//   Stk_Depth/Full/Empty   stack occupancy
//   Stk_Err                sticky overflow / underflow / push+pop indicator
module flag_register_stack #(
  parameter int FLAG_W      = 4,
  parameter int STACK_DEPTH = 4,
  parameter int CNT_W       = $clog2(STACK_DEPTH + 1)
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [FLAG_W-1:0] Flags_in,
  input  logic [FLAG_W-1:0] Flag_Mask,
  input  logic              FR_Ld,
  input  logic              Push,
  input  logic              Pop,
  input  logic              Err_Clr,
  input  logic [3:0]        Cond,
  output logic [FLAG_W-1:0] Flags_out,
  output logic              Cond_True,
  output logic [CNT_W-1:0]  Stk_Depth,
  output logic              Stk_Full,
  output logic              Stk_Empty,
  output logic              Stk_Err
);

  // Index width for the stack array; a single-entry stack still needs one bit.
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [FLAG_W-1:0] flags_q, flags_d;
  logic [CNT_W-1:0]  depth_q, depth_d;
  logic              err_q, err_d;
  logic [FLAG_W-1:0] stack_q [STACK_DEPTH];

  logic              full, empty;
  logic              do_push, do_pop, stk_err_evt;
  logic [CNT_W-1:0]  rd_cnt;
  logic [IDX_W-1:0]  wr_idx, rd_idx;

  assign full   = (depth_q == CNT_W'(STACK_DEPTH));
  assign empty  = (depth_q == '0);
  assign rd_cnt = depth_q - CNT_W'(1);
  assign wr_idx = depth_q[IDX_W-1:0];
  assign rd_idx = rd_cnt[IDX_W-1:0];

  always_comb begin
    do_push     = Push & ~Pop & ~full;
    do_pop      = Pop & ~Push & ~empty;
    // Any push/pop that cannot be honoured is an error, including both at once.
    stk_err_evt = (Push & Pop) | (Push & ~Pop & full) | (Pop & ~Push & empty);

    // A successful pop overrides a same-cycle load; a rejected pop does not.
    flags_d = flags_q;
    if (do_pop) begin
      flags_d = stack_q[rd_idx];
    end else if (FR_Ld) begin
      flags_d = (flags_q & ~Flag_Mask) | (Flags_in & Flag_Mask);
    end

    depth_d = depth_q;
    if (do_push) begin
      depth_d = depth_q + CNT_W'(1);
    end else if (do_pop) begin
      depth_d = rd_cnt;
    end

    // A new error beats a same-cycle clear.
    err_d = err_q;
    if (stk_err_evt) begin
      err_d = 1'b1;
    end else if (Err_Clr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      flags_q <= '0;
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

  // Stack storage is not reset: entries above the depth pointer are never read.
  always_ff @(posedge Clk) begin
    if (do_push) begin
      stack_q[wr_idx] <= flags_q;
    end
  end

  // Condition evaluation uses only the NZCV bits.
  logic f_n, f_z, f_c, f_v;
  assign f_n = flags_q[3];
  assign f_z = flags_q[2];
  assign f_c = flags_q[1];
  assign f_v = flags_q[0];

  always_comb begin
    Cond_True = 1'b0;
    case (Cond)
      4'h0: Cond_True = f_z;
      4'h1: Cond_True = ~f_z;
      4'h2: Cond_True = f_c;
      4'h3: Cond_True = ~f_c;
      4'h4: Cond_True = f_n;
      4'h5: Cond_True = ~f_n;
      4'h6: Cond_True = f_v;
      4'h7: Cond_True = ~f_v;
      4'h8: Cond_True = f_c & ~f_z;
      4'h9: Cond_True = ~f_c | f_z;
      4'hA: Cond_True = (f_n == f_v);
      4'hB: Cond_True = (f_n != f_v);
      4'hC: Cond_True = ~f_z & (f_n == f_v);
      4'hD: Cond_True = f_z | (f_n != f_v);
      4'hE: Cond_True = 1'b1;
      default: Cond_True = 1'b0;
    endcase
  end

  assign Flags_out = flags_q;
  assign Stk_Depth = depth_q;
  assign Stk_Full  = full;
  assign Stk_Empty = empty;
  assign Stk_Err   = err_q;

endmodule

// File: tb/tb_flag_register_stack.sv
// Bench for flag_register_stack: a stimulus process drives one command per cycle
// and queues the expected visible state; a monitor compares on the falling edge.
// The reference keeps the shadow stack as a plain SystemVerilog queue.
module tb_flag_register_stack;
  localparam int FW = 6;
  localparam int SD = 4;
  localparam int CW = $clog2(SD + 1);

  logic          Clk = 1'b0;
  logic          Rst_n = 1'b0;
  logic [FW-1:0] Flags_in = '0;
  logic [FW-1:0] Flag_Mask = '0;
  logic          FR_Ld = 1'b0;
  logic          Push = 1'b0;
  logic          Pop = 1'b0;
  logic          Err_Clr = 1'b0;
  logic [3:0]    Cond = 4'h0;
  logic [FW-1:0] Flags_out;
  logic          Cond_True;
  logic [CW-1:0] Stk_Depth;
  logic          Stk_Full;
  logic          Stk_Empty;
  logic          Stk_Err;

  flag_register_stack #(.FLAG_W(FW), .STACK_DEPTH(SD)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Flags_in(Flags_in), .Flag_Mask(Flag_Mask),
    .FR_Ld(FR_Ld), .Push(Push), .Pop(Pop), .Err_Clr(Err_Clr), .Cond(Cond),
    .Flags_out(Flags_out), .Cond_True(Cond_True), .Stk_Depth(Stk_Depth),
    .Stk_Full(Stk_Full), .Stk_Empty(Stk_Empty), .Stk_Err(Stk_Err)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [FW-1:0] flags;
    int            depth;
    logic          err;
    logic          ct;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  // Reference state
  logic [FW-1:0] m_flags = '0;
  logic [FW-1:0] m_stk[$];
  logic          m_err = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic cond_eval(input logic [3:0] c, input logic [FW-1:0] f);
    logic n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // One cycle of stimulus: set inputs between edges, queue what the DUT must show
  // now (before the next edge), then advance the reference across that edge.
  task automatic drive(input logic rst, input logic ld, input logic [FW-1:0] fin,
                       input logic [FW-1:0] msk, input logic psh, input logic pp,
                       input logic clr, input logic [3:0] c);
    exp_t e;
    logic popped;
    logic bad;
    @(posedge Clk);
    #1;
    Rst_n = rst; FR_Ld = ld; Flags_in = fin; Flag_Mask = msk;
    Push = psh; Pop = pp; Err_Clr = clr; Cond = c;
    if (!rst) begin
      m_flags = '0; m_err = 1'b0; m_stk.delete();
    end
    e.flags = m_flags; e.depth = m_stk.size(); e.err = m_err;
    e.ct = cond_eval(c, m_flags);
    exp_q.push_back(e);
    if (rst) begin
      popped = 1'b0; bad = 1'b0;
      if (psh && pp) bad = 1'b1;
      else if (pp) begin
        if (m_stk.size() == 0) bad = 1'b1;
        else begin m_flags = m_stk.pop_back(); popped = 1'b1; end
      end else if (psh) begin
        if (m_stk.size() == SD) bad = 1'b1;
        else m_stk.push_back(m_flags);
      end
      if (!popped && ld) m_flags = (m_flags & ~msk) | (fin & msk);
      if (bad) m_err = 1'b1;
      else if (clr) m_err = 1'b0;
    end
  endtask

  task automatic idle(input logic [3:0] c);
    drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, c);
  endtask

  // Monitor: the DUT presents its state every cycle; compare whenever an expectation is pending.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("flags_out", int'(Flags_out), int'(e.flags));
        chk("stk_depth", int'(Stk_Depth), e.depth);
        chk("stk_full",  int'(Stk_Full),  int'(e.depth == SD));
        chk("stk_empty", int'(Stk_Empty), int'(e.depth == 0));
        chk("stk_err",   int'(Stk_Err),   int'(e.err));
        chk("cond_true", int'(Cond_True), int'(e.ct));
      end
    end
  end

  initial begin
    // Reset
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 4'h1);
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 4'h0);
    // Full load 1010, then LT / EQ
    drive(1'b1, 1'b1, 6'b001010, 6'b111111, 1'b0, 1'b0, 1'b0, 4'hB);
    idle(4'hB);
    idle(4'h0);
    // Masked load from 1111
    drive(1'b1, 1'b1, 6'b111111, 6'b111111, 1'b0, 1'b0, 1'b0, 4'hE);
    drive(1'b1, 1'b1, 6'b000000, 6'b000101, 1'b0, 1'b0, 1'b0, 4'hF);
    drive(1'b1, 1'b0, 6'b000000, 6'b111111, 1'b0, 1'b0, 1'b0, 4'h8);
    idle(4'h9);
    // Push 1,2,3,4 then overflow, then four pops
    drive(1'b1, 1'b1, 6'd1, 6'b111111, 1'b0, 1'b0, 1'b0, 4'h2);
    for (int i = 2; i <= 4; i++)
      drive(1'b1, 1'b1, FW'(i), 6'b111111, 1'b1, 1'b0, 1'b0, 4'h4);
    drive(1'b1, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 4'hA);
    drive(1'b1, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 4'hC);
    for (int i = 0; i < 4; i++)
      drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 4'hD);
    idle(4'h3);
    // Clear error, push with load, pop with load
    drive(1'b1, 1'b1, 6'b000100, 6'b111111, 1'b0, 1'b0, 1'b1, 4'h0);
    drive(1'b1, 1'b1, 6'b001000, 6'b111111, 1'b1, 1'b0, 1'b0, 4'h5);
    drive(1'b1, 1'b1, 6'b000001, 6'b111111, 1'b0, 1'b1, 1'b0, 4'h6);
    idle(4'h7);
    // Underflow with load, push+pop together, then clear
    drive(1'b1, 1'b1, 6'b110010, 6'b110000, 1'b0, 1'b1, 1'b0, 4'h0);
    drive(1'b1, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0, 4'h0);
    drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 4'h0);
    // Error and clear together: error wins
    drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 4'h0);
    drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 4'h0);
    // Push twice, asynchronous reset between edges, pop after release
    drive(1'b1, 1'b1, 6'b101111, 6'b111111, 1'b1, 1'b0, 1'b0, 4'hE);
    drive(1'b1, 1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 4'hE);
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 4'h1);
    drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 4'h1);
    idle(4'h1);
    drive(1'b1, 1'b1, 6'b010101, 6'b111111, 1'b1, 1'b0, 1'b1, 4'h0);
    drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 4'h0);
    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      int r;
      logic rs, ps, pp;
      r  = $urandom_range(0, 99);
      rs = ($urandom_range(0, 199) != 0);
      ps = (r < 30) || (r >= 95);
      pp = (r >= 30 && r < 60) || (r >= 95);
      drive(rs, ($urandom_range(0, 1) == 1), FW'($urandom), FW'($urandom),
            ps, pp, ($urandom_range(0, 9) == 0), 4'($urandom));
    end
    idle(4'h0);
    // Let the monitor drain, bounded
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge Clk);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
